// File: rtl/test_dram_top_pkg.sv
// Shared types and constants for the memory self-test: FSM states, data pattern and report strings.
package test_dram_top_pkg;

  typedef enum logic [2:0] {
    StInit,
    StWrite,
    StRead,
    StReport,
    StDone
  } state_e;

  localparam logic [31:0] PatternKey = 32'hA5A5_5A5A;
  localparam int unsigned MsgLen = 6;
  localparam logic [47:0] PassMsg = {"PASS", 8'h0D, 8'h0A};
  localparam logic [47:0] FailMsg = {"FAIL", 8'h0D, 8'h0A};

  function automatic logic [31:0] pattern32(input logic [31:0] addr);
    return addr ^ PatternKey;
  endfunction

  // First character sits in the top byte, so shift left and take the top byte.
  function automatic logic [7:0] msg_byte(input logic fail, input logic [2:0] idx);
    logic [47:0] msg;
    msg = fail ? FailMsg : PassMsg;
    msg = msg << {idx, 3'b000};
    return msg[47:40];
  endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 serial transmitter with a valid/ready byte interface; ready is high only while idle.
module uart_tx #(
  parameter int unsigned ClockFreq = 200_000_000,
  parameter int unsigned Baud      = 9600
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] DataIn,
  input  logic       DataInValid,
  output logic       DataInReady,
  output logic       SOut
);

  localparam int unsigned Period = ClockFreq / Baud;
  localparam int unsigned CntW   = $clog2(Period + 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(Period - 1);
  // The idle cycle that accepts the next byte supplies the final stop-bit cycle.
  localparam logic [CntW-1:0] StopCnt = CntW'(Period - 2);

  logic            r_busy, w_busy_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic [3:0]      r_bit, w_bit_d;
  logic [9:0]      r_shift, w_shift_d;
  logic [CntW-1:0] w_limit;

  always_comb begin
    w_busy_d  = r_busy;
    w_cnt_d   = r_cnt;
    w_bit_d   = r_bit;
    w_shift_d = r_shift;
    w_limit   = (r_bit == 4'd9) ? StopCnt : FullCnt;
    if (!r_busy) begin
      if (DataInValid) begin
        w_busy_d  = 1'b1;
        w_cnt_d   = '0;
        w_bit_d   = '0;
        w_shift_d = {1'b1, DataIn, 1'b0};
      end
    end else if (r_cnt == w_limit) begin
      w_cnt_d = '0;
      if (r_bit == 4'd9) begin
        w_busy_d = 1'b0;
      end else begin
        w_bit_d   = r_bit + 4'd1;
        w_shift_d = {1'b1, r_shift[9:1]};
      end
    end else begin
      w_cnt_d = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '1;
    end else begin
      r_busy  <= w_busy_d;
      r_cnt   <= w_cnt_d;
      r_bit   <= w_bit_d;
      r_shift <= w_shift_d;
    end
  end

  assign DataInReady = ~r_busy;
  assign SOut        = r_busy ? r_shift[0] : 1'b1;

endmodule

// File: rtl/test_dram_top.sv
// Memory self-test: write a pattern, read it back, report PASS/FAIL over UART; restart on button.
// Define ERROR_INJECT_EN to corrupt bit 0 of every write to address 5.
module test_dram_top
  import test_dram_top_pkg::*;
#(
  parameter int unsigned ClockFreq = 200_000_000,
  parameter int unsigned Baud      = 9600,
  parameter int unsigned Depth     = 256,
  parameter int unsigned DataWidth = 32
) (
  input  logic sys_clk_p,
  input  logic sys_clk_n,
  input  logic sys_rst,
  input  logic GPIO_SW_C,
  output logic uart_txd
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam logic [AddrW-1:0] LastAddr = AddrW'(Depth - 1);

  state_e               r_state, w_state_d;
  logic [AddrW-1:0]     r_addr, w_addr_d;
  logic [AddrW-1:0]     r_cmp_addr, w_cmp_addr_d;
  logic                 r_cmp_vld, w_cmp_vld_d;
  logic                 r_rd_last, w_rd_last_d;
  logic                 r_fail, w_fail_d;
  logic [2:0]           r_char, w_char_d;
  logic                 r_sync1, r_sync2, r_sync3;
  logic                 w_btn_rise;
  logic                 w_mem_we;
  logic                 w_tx_valid, w_tx_ready;
  logic [7:0]           w_tx_data;
  logic [DataWidth-1:0] r_mem [Depth];
  logic [DataWidth-1:0] r_rdata, w_wdata, w_exp;
  logic                 w_unused_clk_n;

  assign w_unused_clk_n = sys_clk_n;

  always_comb begin
    w_wdata = DataWidth'(pattern32(32'(r_addr)));
`ifdef ERROR_INJECT_EN
    if (r_addr == AddrW'(5)) w_wdata[0] = ~w_wdata[0];
`endif
  end

  assign w_exp      = DataWidth'(pattern32(32'(r_cmp_addr)));
  assign w_btn_rise = r_sync2 & ~r_sync3;
  assign w_tx_data  = msg_byte(r_fail, r_char);

  // Single-port RAM, read-first; intentionally not reset.
  always_ff @(posedge sys_clk_p) begin
    if (w_mem_we) r_mem[r_addr] <= w_wdata;
    r_rdata <= r_mem[r_addr];
  end

  always_comb begin
    w_state_d    = r_state;
    w_addr_d     = r_addr;
    w_cmp_addr_d = r_cmp_addr;
    w_cmp_vld_d  = 1'b0;
    w_rd_last_d  = r_rd_last;
    w_fail_d     = r_fail;
    w_char_d     = r_char;
    w_mem_we     = 1'b0;
    w_tx_valid   = 1'b0;
    if (r_cmp_vld && (r_rdata != w_exp)) w_fail_d = 1'b1;
    unique case (r_state)
      StInit: begin
        w_state_d   = StWrite;
        w_addr_d    = '0;
        w_rd_last_d = 1'b0;
        w_char_d    = '0;
      end
      StWrite: begin
        w_mem_we = 1'b1;
        if (r_addr == LastAddr) begin
          w_addr_d    = '0;
          w_rd_last_d = 1'b0;
          w_state_d   = StRead;
        end else begin
          w_addr_d = r_addr + 1'b1;
        end
      end
      StRead: begin
        if (!r_rd_last) begin
          w_cmp_vld_d  = 1'b1;
          w_cmp_addr_d = r_addr;
          if (r_addr == LastAddr) w_rd_last_d = 1'b1;
          else                    w_addr_d    = r_addr + 1'b1;
        end
        if (r_cmp_vld && (r_cmp_addr == LastAddr)) begin
          w_state_d = StReport;
          w_char_d  = '0;
        end
      end
      StReport: begin
        if (r_char < 3'(MsgLen)) begin
          w_tx_valid = 1'b1;
          if (w_tx_ready) w_char_d = r_char + 3'd1;
        end else if (w_tx_ready) begin
          // Last character has fully left the shifter.
          w_state_d = StDone;
        end
      end
      StDone: begin
        if (w_btn_rise) begin
          w_state_d   = StWrite;
          w_addr_d    = '0;
          w_fail_d    = 1'b0;
          w_rd_last_d = 1'b0;
          w_char_d    = '0;
        end
      end
      default: w_state_d = StInit;
    endcase
  end

  always_ff @(posedge sys_clk_p or posedge sys_rst) begin
    if (sys_rst) begin
      r_state    <= StInit;
      r_addr     <= '0;
      r_cmp_addr <= '0;
      r_cmp_vld  <= 1'b0;
      r_rd_last  <= 1'b0;
      r_fail     <= 1'b0;
      r_char     <= '0;
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_sync3    <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_addr     <= w_addr_d;
      r_cmp_addr <= w_cmp_addr_d;
      r_cmp_vld  <= w_cmp_vld_d;
      r_rd_last  <= w_rd_last_d;
      r_fail     <= w_fail_d;
      r_char     <= w_char_d;
      r_sync1    <= GPIO_SW_C;
      r_sync2    <= r_sync1;
      r_sync3    <= r_sync2;
    end
  end

  uart_tx #(
    .ClockFreq(ClockFreq),
    .Baud     (Baud)
  ) u_uart_tx (
    .Clock      (sys_clk_p),
    .Reset      (sys_rst),
    .DataIn     (w_tx_data),
    .DataInValid(w_tx_valid),
    .DataInReady(w_tx_ready),
    .SOut       (uart_txd)
  );

endmodule

// File: tb/tb_test_dram_top.sv
// Directed bench: decodes the UART report, exercises restart/reset behaviour and default bit timing.
module tb_test_dram_top;

  localparam int unsigned TbClk   = 2_000_000;
  localparam int unsigned TbBaud  = 100_000;
  localparam int unsigned BitCyc  = 20;
  localparam int unsigned TbDepth = 16;

  logic       clk = 1'b0;
  logic       clk_n;
  logic       rst = 1'b1;
  logic       btn = 1'b0;
  logic       txd;
  logic       u_rst = 1'b1;
  logic       u_valid = 1'b0;
  logic [7:0] u_data = 8'h00;
  logic       u_ready;
  logic       u_sout;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_msg [6];

  always #5ns clk = ~clk;
  assign clk_n = ~clk;

  test_dram_top #(
    .ClockFreq(TbClk),
    .Baud     (TbBaud),
    .Depth    (TbDepth),
    .DataWidth(32)
  ) u_dut (
    .sys_clk_p(clk),
    .sys_clk_n(clk_n),
    .sys_rst  (rst),
    .GPIO_SW_C(btn),
    .uart_txd (txd)
  );

  uart_tx #(
    .ClockFreq(200_000_000),
    .Baud     (9600)
  ) u_tx_def (
    .Clock      (clk),
    .Reset      (u_rst),
    .DataIn     (u_data),
    .DataInValid(u_valid),
    .DataInReady(u_ready),
    .SOut       (u_sout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Frame is {stop, data[7:0], start}; stays all-ones if no start bit shows up.
  task automatic rx_frame(output logic [9:0] fr);
    bit found;
    found = 1'b0;
    fr    = '1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (txd == 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    if (found) begin
      repeat (BitCyc / 2) @(negedge clk);
      fr[0] = txd;
      for (int k = 1; k < 10; k++) begin
        repeat (BitCyc) @(negedge clk);
        fr[k] = txd;
      end
    end
  endtask

  task automatic rx_msg(input string tag);
    logic [9:0] fr;
    for (int i = 0; i < 6; i++) begin
      rx_frame(fr);
      check($sformatf("%s_byte%0d", tag, i), {22'd0, fr}, {22'd0, 1'b1, exp_msg[i], 1'b0});
    end
  endtask

  task automatic check_idle(input string tag, input int n);
    int lows;
    lows = 0;
    repeat (n) begin
      @(negedge clk);
      if (txd == 1'b0) lows++;
    end
    check(tag, lows, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [9:0]  fr;
    logic [31:0] width;
    logic [31:0] width_ok;
    bit          seen;

`ifdef ERROR_INJECT_EN
    exp_msg = '{8'h46, 8'h41, 8'h49, 8'h4C, 8'h0D, 8'h0A};
`else
    exp_msg = '{8'h50, 8'h41, 8'h53, 8'h53, 8'h0D, 8'h0A};
`endif

    #200ns;
    @(negedge clk);
    check("rst_txd_high", txd, 1);
    rst   = 1'b0;
    u_rst = 1'b0;

    rx_msg("first");
    check_idle("idle_after_first", 300);

    btn = 1'b1;
    repeat (10) @(negedge clk);
    btn = 1'b0;
    rx_msg("restart");
    check_idle("idle_after_restart", 300);

    // Button edge lands while WRITE is running and must be ignored.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    btn = 1'b1;
    repeat (3) @(negedge clk);
    btn = 1'b0;
    rx_msg("wr_pulse");
    check_idle("single_report", 300);

    // Reset in the middle of the second character.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rx_frame(fr);
    check("mid_first_byte", {22'd0, fr}, {22'd0, 1'b1, exp_msg[0], 1'b0});
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (txd == 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
    check("second_start_seen", seen, 1);
    repeat (50) @(negedge clk);
    check("second_bit1_low", txd, 0);
    rst = 1'b1;
    #1ns;
    check("async_rst_txd", txd, 1);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    rx_msg("after_rst");
    check_idle("idle_after_rst", 300);

    // Start-bit width at 200 MHz / 9600 baud.
    check("def_ready_idle", u_ready, 1);
    u_data  = 8'h55;
    u_valid = 1'b1;
    @(negedge clk);
    u_valid = 1'b0;
    check("def_ready_busy", u_ready, 0);
    width = 0;
    while (u_sout == 1'b0 && width < 25000) begin
      @(negedge clk);
      width++;
    end
    width_ok = (width >= 20832 && width <= 20834) ? 32'd20833 : width;
    check("start_bit_width", width_ok, 20833);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/test_dram_top.md
TEST_DRAM_TOP -- requirements
Module: test_dram_top

Interface
REQ-001 The module SHALL have parameter ClockFreq, default 200_000_000, meaning the input clock frequency in Hz.
REQ-002 The module SHALL have parameter Baud, default 9600, meaning the UART bit rate.
REQ-003 The module SHALL have parameter Depth, default 256, meaning the number of words under test (power of two, at least 16).
REQ-004 The module SHALL have parameter DataWidth, default 32, meaning the word width in bits.
REQ-005 The module SHALL have port sys_clk_p, input, 1 bit, the single system clock; all logic is clocked on its rising edge.
REQ-006 The module SHALL have port sys_clk_n, input, 1 bit, the complementary clock leg, which is unused in RTL.
REQ-007 The module SHALL have port sys_rst, input, 1 bit, reset: asynchronous, active-high.
REQ-008 The module SHALL have port GPIO_SW_C, input, 1 bit, an asynchronous restart push-button, active-high.
REQ-009 The module SHALL have port uart_txd, output, 1 bit, serial 8N1 transmit line that idles high.

Function
REQ-010 The block SHALL implement states INIT, WRITE, READ, REPORT and DONE.
REQ-011 INIT SHALL last one cycle after reset release, then go to WRITE.
REQ-012 In WRITE, the block SHALL write pattern P(a) = zero-extended a XOR 32'hA5A5_5A5A (truncated to DataWidth) to addresses 0..Depth-1, one address per cycle, then go to READ.
REQ-013 In READ, the block SHALL issue one read per cycle for addresses 0..Depth-1; memory read latency is 1 cycle.
REQ-014 In READ, each returned word SHALL be compared to P of its address; any mismatch sets a sticky fail flag.
REQ-015 After the last compare, the block SHALL enter REPORT.
REQ-016 REPORT SHALL transmit the ASCII string "PASS\r\n" if fail is clear, else "FAIL\r\n", then enter DONE.
REQ-017 UART framing SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), with no inter-byte gap beyond the stop bit.
REQ-018 The bit period SHALL be ClockFreq/Baud cycles (integer division): 20833 cycles at the defaults.
REQ-019 In DONE, uart_txd SHALL remain high.
REQ-020 In DONE, a synchronized rising edge of GPIO_SW_C SHALL clear fail and go to WRITE.
REQ-021 GPIO_SW_C SHALL be double-flop synchronized, then edge-detected.
REQ-022 GPIO_SW_C edges outside DONE SHALL be ignored; a button held high across DONE entry does not trigger a restart (edge only).
REQ-023 Address counters SHALL use clog2(Depth) bits and SHALL stop at Depth-1 (no wrap into a second pass).

Reset
REQ-024 Asserting sys_rst SHALL immediately force: state INIT, uart_txd=1, fail=0, counters=0, synchronizer flops=0.
REQ-025 Reset mid-operation (including mid-byte) SHALL abort the operation without completing the character.
REQ-026 Memory contents SHALL NOT be reset.

Configuration
REQ-027 With ERROR_INJECT_EN defined, every write to address 5 SHALL store P(5) with bit 0 inverted, so each test reports FAIL.
REQ-028 Without ERROR_INJECT_EN, writes SHALL be unmodified.

Structure
REQ-029 A shared package SHALL hold the state enum, the pattern constant 32'hA5A5_5A5A, and the PASS/FAIL byte strings.
REQ-030 Sub-module uart_tx SHALL have parameters ClockFreq and Baud and ports Clock, Reset, DataIn[7:0], DataInValid, DataInReady and SOut, with a valid/ready handshake: a byte is accepted when both are high, and ready is high only when idle.
REQ-031 The memory under test SHALL be an inferred single-port synchronous RAM inside test_dram_top.

Verification
REQ-032 Bench SHALL cover: defaults, reset held 200 ns -> external 9600-baud receiver decodes exactly 'P','A','S','S',0x0D,0x0A; uart_txd stays 1 afterward.
REQ-033 Bench SHALL cover: ERROR_INJECT_EN defined -> receiver decodes "FAIL\r\n".
REQ-034 Bench SHALL cover: after DONE, pulse GPIO_SW_C high 10 cycles -> a second "PASS\r\n" is received.
REQ-035 Bench SHALL cover: GPIO_SW_C pulsed during WRITE -> exactly one "PASS\r\n" is received.
REQ-036 Bench SHALL cover: sys_rst asserted mid-'A' transmit -> uart_txd is 1 within the same cycle, and a complete "PASS\r\n" follows after release.
REQ-037 Bench SHALL cover: measure the start-bit width -> 20833 cycles ±1 at ClockFreq=200_000_000.
